keypad_scan_ctrl: RTL
=====================

// Module: keypad_scan_ctrl
// PURPOSE
//  Sequencer for the 4x4 matrix keypad front end:
//  - drives one-hot row scanning, detects the pressed column, and debounces press and release;
//  - hands one key code per physical press to the capture/operand FSM over a valid/ready handshake.
//  Runs in the 27 MHz system clock domain; downstream modules see only clean, synchronous key events.
// PARAMETERS
//  CLK_FREQ   27_000_000  system clock frequency in Hz
//  SCAN_FREQ  1_000       scan tick rate in Hz; each row is driven for one tick period
//  DEB_TICKS  10          consecutive stable ticks required to accept a press or a release
// PORTS
//  clk        in   1  system clock, 27 MHz
//  rst        in   1  asynchronous reset, active-low
//  col_n      in   4  keypad columns, active-low (pulled up), asynchronous to clk
//  row_n      out  4  keypad row drive, one-hot active-low
//  key_code   out  4  code of the accepted key; stable while key_valid=1
//  key_valid  out  1  key_code holds an unconsumed key
//  key_ready  in   1  consumer accepts the key in any cycle where key_valid & key_ready
//  overrun    out  1  one-cycle pulse: a press was accepted while key_valid=1; that press is dropped
// BEHAVIOUR
//  Reset (rst=0, takes effect immediately, also mid-operation):
//  - row_n=4'b1110; key_code=0; key_valid=0; overrun=0.
//  - state=SCAN; row_idx=0; tick counter=0; deb_cnt=0; col synchroniser flops=4'b1111.
//  Tick:
//  - TICK_DIV=CLK_FREQ/SCAN_FREQ; counter runs 0..TICK_DIV-1 and wraps.
//  - tick is a 1-cycle pulse while count==TICK_DIV-1.
//  Column sampling: col_n passes a 2-FF synchroniser (col_s); col_s is evaluated only on tick cycles.
//  Row drive: row_n=~(4'b0001<<row_idx), registered; it changes only on tick cycles.
//  FSM, all transitions on tick cycles only:
//  - SCAN: if col_s==4'b1111, row_idx<=row_idx+1 (wraps 3->0).
//    Otherwise latch row_idx and the lowest-index low column (col_idx), set deb_cnt=1,
//    go DEBOUNCE. row_idx stays frozen.
//  - DEBOUNCE: if col_s[col_idx]==0, deb_cnt++; when deb_cnt reaches DEB_TICKS, go PRESS.
//    If col_s[col_idx]==1, go SCAN and advance row_idx (glitch rejected, no event).
//  - PRESS: transient state. Acts on the next clk, not on a tick.
//    If key_valid==0: key_code<=map(row_idx,col_idx), key_valid<=1.
//    Else: overrun pulses for 1 cycle and key_code is unchanged. Then go HOLD.
//  - HOLD: if col_s==4'b1111, set deb_cnt=1 and go RELEASE; otherwise stay.
//  - RELEASE: if col_s==4'b1111, deb_cnt++; when deb_cnt reaches DEB_TICKS, go SCAN
//    and advance row_idx. If any column goes low, go HOLD (bounce on release).
//  - Only one key event per physical press; holding a key never repeats.
//  - A second key pressed while in HOLD/RELEASE is ignored until a full release.
//  Handshake:
//  - key_valid clears on the cycle after key_valid & key_ready.
//  - If PRESS and the handshake fall in the same cycle, the new key loads:
//    key_valid stays 1 with the new code and there is no overrun.
//  Latency: key_valid rises 1 clk after the DEB_TICKS-th stable tick.
//  Key map: row0 1,2,3,A | row1 4,5,6,B | row2 7,8,9,C | row3 *,0,#,D (cols 0..3).
//  Codes: digits 0-9 -> 4'h0-4'h9; A-D -> 4'hA-4'hD; * -> 4'hE; # -> 4'hF.
//  Width: deb_cnt is $clog2(DEB_TICKS+1) bits and saturates at DEB_TICKS; tick counter is $clog2(TICK_DIV) bits.
// STRUCTURE
//  Package keypad_pkg:
//  - typedef enum logic [2:0] {SCAN, DEBOUNCE, PRESS, HOLD, RELEASE} kp_state_t;
//  - KEY_STAR=4'hE, KEY_HASH=4'hF;
//  - function key_map(row, col) returning logic [3:0].
//  Sub-module: scan_tick_gen (#CLK_FREQ, SCAN_FREQ) -> tick. It is the only sub-module.
//  Synchroniser, row register, FSM and output register stay inline.
// TESTING (CLK_FREQ=1000, SCAN_FREQ=100 -> tick every 10 clk; DEB_TICKS=3)
//  1. Reset, no key.
//     -> row_n cycles 1110,1101,1011,0111,1110 every 10 clk; key_valid stays 0.
//  2. Hold col_n=1101 while row_n=1101 (key 5), key_ready=1.
//     -> exactly one key_valid pulse with key_code=4'h5; no repeat while held.
//  3. Key 5 bounces (col low for 1 tick, high for 1 tick) then holds stable.
//     -> no event during the bounce; one event 4'h5 once 3 stable ticks are seen.
//  4. key_ready=0: press # (row3,col2) -> key_code=4'hF, key_valid=1 held.
//     Release, then press 7 -> overrun pulses once, key_code stays 4'hF.
//     Then key_ready=1 -> key_valid clears next cycle.
//  5. Release bounce on key 0: col low/high/low, then stable high.
//     -> single event 4'h0; scanning resumes only after 3 stable-high ticks.
//  6. Drive rst=0 during DEBOUNCE, then release it.
//     -> immediately row_n=1110 and key_valid=0; no stale key after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and key-code mapping for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {SCAN, DEBOUNCE, PRESS, HOLD, RELEASE} kp_state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    unique case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_FREQ/SCAN_FREQ clocks.
module scan_tick_gen #(
  parameter int unsigned CLK_FREQ  = 27_000_000,
  parameter int unsigned SCAN_FREQ = 1_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned TickDiv = CLK_FREQ / SCAN_FREQ;
  localparam int unsigned CntW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntMax);
  assign tick   = w_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with press/release debounce and a valid/ready key output.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 27_000_000,
  parameter int unsigned SCAN_FREQ = 1_000,
  parameter int unsigned DEB_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun
);

  localparam int unsigned DebW = $clog2(DEB_TICKS + 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEB_TICKS);
  localparam logic [DebW-1:0] DebOne = DebW'(1);

  logic            w_tick;
  logic [3:0]      r_col_s1, r_col_s2;
  kp_state_t       r_state, w_state_d;
  logic [1:0]      r_row_idx, w_row_idx_d;
  logic [1:0]      r_col_idx, w_col_idx_d;
  logic [DebW-1:0] r_deb_cnt, w_deb_cnt_d, w_deb_inc;
  logic [3:0]      r_row_n;
  logic [3:0]      r_key_code, w_key_code_d;
  logic            r_key_valid, w_key_valid_d;
  logic            r_overrun, w_overrun_d;
  logic            w_all_high;
  logic [1:0]      w_low_col;

  scan_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .SCAN_FREQ(SCAN_FREQ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  assign w_all_high = (r_col_s2 == 4'b1111);
  assign w_deb_inc  = (r_deb_cnt >= DebMax) ? DebMax : r_deb_cnt + 1'b1;

  // Lowest-index active column wins when several are low.
  always_comb begin
    w_low_col = 2'd3;
    if (!r_col_s2[0])      w_low_col = 2'd0;
    else if (!r_col_s2[1]) w_low_col = 2'd1;
    else if (!r_col_s2[2]) w_low_col = 2'd2;
  end

  always_comb begin
    w_state_d     = r_state;
    w_row_idx_d   = r_row_idx;
    w_col_idx_d   = r_col_idx;
    w_deb_cnt_d   = r_deb_cnt;
    w_key_code_d  = r_key_code;
    w_key_valid_d = r_key_valid;
    w_overrun_d   = 1'b0;

    if (r_key_valid && key_ready) w_key_valid_d = 1'b0;

    unique case (r_state)
      SCAN: if (w_tick) begin
        if (w_all_high) begin
          w_row_idx_d = r_row_idx + 1'b1;
        end else begin
          w_col_idx_d = w_low_col;
          w_deb_cnt_d = DebOne;
          w_state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: if (w_tick) begin
        if (!r_col_s2[r_col_idx]) begin
          w_deb_cnt_d = w_deb_inc;
          if (w_deb_inc == DebMax) w_state_d = PRESS;
        end else begin
          w_row_idx_d = r_row_idx + 1'b1;
          w_state_d   = SCAN;
        end
      end
      // A same-cycle handshake frees the slot, so the new key loads without overrun.
      PRESS: begin
        if (!r_key_valid || key_ready) begin
          w_key_code_d  = key_map(r_row_idx, r_col_idx);
          w_key_valid_d = 1'b1;
        end else begin
          w_overrun_d = 1'b1;
        end
        w_state_d = HOLD;
      end
      HOLD: if (w_tick && w_all_high) begin
        w_deb_cnt_d = DebOne;
        w_state_d   = RELEASE;
      end
      RELEASE: if (w_tick) begin
        if (w_all_high) begin
          w_deb_cnt_d = w_deb_inc;
          if (w_deb_inc == DebMax) begin
            w_row_idx_d = r_row_idx + 1'b1;
            w_state_d   = SCAN;
          end
        end else begin
          w_state_d = HOLD;
        end
      end
      default: w_state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_s1    <= 4'b1111;
      r_col_s2    <= 4'b1111;
      r_state     <= SCAN;
      r_row_idx   <= 2'd0;
      r_col_idx   <= 2'd0;
      r_deb_cnt   <= '0;
      r_row_n     <= 4'b1110;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_col_s1    <= col_n;
      r_col_s2    <= r_col_s1;
      r_state     <= w_state_d;
      r_row_idx   <= w_row_idx_d;
      r_col_idx   <= w_col_idx_d;
      r_deb_cnt   <= w_deb_cnt_d;
      r_row_n     <= ~(4'b0001 << w_row_idx_d);
      r_key_code  <= w_key_code_d;
      r_key_valid <= w_key_valid_d;
      r_overrun   <= w_overrun_d;
    end
  end

  assign row_n     = r_row_n;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign overrun   = r_overrun;

endmodule
